// File: rtl/gb_vram_pkg.sv
// Shared types and constants for the VRAM port arbiter.
package gb_vram_pkg;

  typedef enum logic [1:0] {
    S_CPU   = 2'd0,
    S_PPU   = 2'd1,
    S_FLUSH = 2'd2
  } vram_owner_e;

  localparam logic [1:0] PPU_MODE_DRAW = 2'd3;
  localparam logic [2:0] VRAM_HIT      = 3'b100;
  localparam logic [7:0] CPU_OPEN_BUS  = 8'hFF;

  // Takes only the top three address bits so callers pass exactly the page field.
  function automatic logic is_vram_hit(input logic [2:0] page);
    return page == VRAM_HIT;
  endfunction

endpackage

// File: rtl/gb_vram_post_buf.sv
// Single-entry buffer holding the most recent CPU write blocked during drawing.
module gb_vram_post_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        capture,
  input  logic [15:0] capture_addr,
  input  logic [7:0]  capture_data,
  input  logic        clear,
  output logic        pending,
  output logic [15:0] addr,
  output logic [7:0]  data
);
  import gb_vram_pkg::*;

  logic        pending_reg;
  logic [15:0] addr_reg;
  logic [7:0]  data_reg;

  // Capture has priority: a newer blocked write always replaces the entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg <= 1'b0;
      addr_reg    <= 16'h0000;
      data_reg    <= 8'h00;
    end else if (capture) begin
      pending_reg <= 1'b1;
      addr_reg    <= capture_addr;
      data_reg    <= capture_data;
    end else if (clear) begin
      pending_reg <= 1'b0;
    end
  end

  assign pending = pending_reg;
  assign addr    = addr_reg;
  assign data    = data_reg;

endmodule

// File: rtl/gb_vram_arbiter.sv
// Shares the single VRAM port between CPU and PPU fetcher based on PPU mode.
// Optional VRAM_WRITE_POST_EN: post CPU writes blocked during drawing and flush them afterwards.
module gb_vram_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  ppu_mode,
  input  logic        ppu_req,
  input  logic [15:0] ppu_addr,
  output logic [7:0]  ppu_rdata,
  output logic        ppu_valid,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  output logic [15:0] vram_addr,
  output logic [7:0]  vram_wdata,
  output logic        vram_wren,
  input  logic [7:0]  vram_rdata
);
  import gb_vram_pkg::*;

  vram_owner_e state_reg, state_next;

  logic        cpu_hit_req;
  logic        cpu_service;
  logic        ppu_service;
  logic        wren_raw;
  logic        flush_needed;
  logic [15:0] post_addr;
  logic [7:0]  post_data;

  logic        cpu_ack_reg;
  logic [7:0]  cpu_rdata_reg;
  logic        ppu_valid_reg;
  logic [7:0]  ppu_rdata_reg;

  assign cpu_hit_req = cpu_req & is_vram_hit(cpu_addr[15:13]);

`ifdef VRAM_WRITE_POST_EN
  logic post_capture;
  logic post_clear;
  logic post_pending;

  assign post_capture = (state_reg == S_PPU) & cpu_hit_req & cpu_we;
  assign post_clear   = (state_reg == S_FLUSH);
  // A write blocked in the exit cycle itself must still be flushed.
  assign flush_needed = post_pending | post_capture;

  gb_vram_post_buf u_post_buf (
    .clk          (clk),
    .reset        (reset),
    .capture      (post_capture),
    .capture_addr (cpu_addr),
    .capture_data (cpu_wdata),
    .clear        (post_clear),
    .pending      (post_pending),
    .addr         (post_addr),
    .data         (post_data)
  );
`else
  assign flush_needed = 1'b0;
  assign post_addr    = 16'h0000;
  assign post_data    = 8'h00;
`endif

  always_comb begin
    state_next  = state_reg;
    vram_addr   = cpu_addr;
    vram_wdata  = cpu_wdata;
    wren_raw    = 1'b0;
    cpu_service = 1'b0;
    ppu_service = 1'b0;
    case (state_reg)
      S_CPU: begin
        wren_raw    = cpu_hit_req & cpu_we;
        cpu_service = cpu_hit_req;
        if (ppu_mode == PPU_MODE_DRAW) state_next = S_PPU;
      end
      S_PPU: begin
        vram_addr   = ppu_addr;
        cpu_service = cpu_hit_req;
        ppu_service = ppu_req;
        if (ppu_mode != PPU_MODE_DRAW) state_next = flush_needed ? S_FLUSH : S_CPU;
      end
      S_FLUSH: begin
        // CPU is stalled here; it keeps cpu_req high and is served in S_CPU.
        vram_addr  = post_addr;
        vram_wdata = post_data;
        wren_raw   = 1'b1;
        state_next = S_CPU;
      end
      default: state_next = S_CPU;
    endcase
  end

  assign vram_wren = wren_raw & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_CPU;
      cpu_ack_reg   <= 1'b0;
      cpu_rdata_reg <= CPU_OPEN_BUS;
      ppu_valid_reg <= 1'b0;
      ppu_rdata_reg <= 8'h00;
    end else begin
      state_reg   <= state_next;
      cpu_ack_reg <= cpu_service;
      if (cpu_service & ~cpu_we)
        cpu_rdata_reg <= (state_reg == S_PPU) ? CPU_OPEN_BUS : vram_rdata;
      ppu_valid_reg <= ppu_service;
      if (ppu_service) ppu_rdata_reg <= vram_rdata;
    end
  end

  assign cpu_ack   = cpu_ack_reg;
  assign cpu_rdata = cpu_rdata_reg;
  assign ppu_valid = ppu_valid_reg;
  assign ppu_rdata = ppu_rdata_reg;

endmodule

// File: tb/tb_gb_vram_arbiter.sv
// Self-checking bench for gb_vram_arbiter: directed scenarios then randomized traffic.
module tb_gb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ppu_mode;
  logic        ppu_req;
  logic [15:0] ppu_addr;
  logic [7:0]  ppu_rdata;
  logic        ppu_valid;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic [15:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_wren;
  logic [7:0]  vram_rdata;

  always #5 clk = ~clk;

  gb_vram_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .ppu_mode   (ppu_mode),
    .ppu_req    (ppu_req),
    .ppu_addr   (ppu_addr),
    .ppu_rdata  (ppu_rdata),
    .ppu_valid  (ppu_valid),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ack    (cpu_ack),
    .vram_addr  (vram_addr),
    .vram_wdata (vram_wdata),
    .vram_wren  (vram_wren),
    .vram_rdata (vram_rdata)
  );

  // VRAM array: combinational read, write on the clock edge.
  logic [7:0] vram [0:8191];
  assign vram_rdata = vram[vram_addr[12:0]];
  always @(posedge clk) if (vram_wren) vram[vram_addr[12:0]] <= vram_wdata;

`ifdef VRAM_WRITE_POST_EN
  localparam bit POST = 1'b1;
`else
  localparam bit POST = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the port this cycle, the posted entry, and expected memory.
  bit          m_ppu;
  bit          m_flush;
  bit          p_valid;
  logic [15:0] p_addr;
  logic [7:0]  p_data;
  logic [7:0]  mem [0:8191];
  bit          e_ack;
  bit          e_valid;
  logic [7:0]  e_rdata;
  logic [7:0]  e_prdata;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the currently driven inputs.
  task automatic cycle();
    bit          hit, cpu_own, x_wren, n_ppu, n_flush, n_ack, n_valid;
    logic [12:0] x_waddr;
    logic [7:0]  x_wdata, n_rdata, n_prdata;
    #1;
    hit     = (cpu_addr >= 16'h8000) && (cpu_addr <= 16'h9FFF);
    cpu_own = !m_ppu && !m_flush;
    x_wren  = 1'b0;
    x_waddr = '0;
    x_wdata = '0;
    if (!reset && m_flush) begin
      x_wren = 1'b1; x_waddr = p_addr[12:0]; x_wdata = p_data;
    end else if (!reset && cpu_own && cpu_req && cpu_we && hit) begin
      x_wren = 1'b1; x_waddr = cpu_addr[12:0]; x_wdata = cpu_wdata;
    end
    chk("vram_wren", {15'd0, vram_wren}, {15'd0, x_wren});
    if (x_wren) begin
      chk("vram_waddr", {3'd0, vram_addr[12:0]}, {3'd0, x_waddr});
      chk("vram_wdata", {8'd0, vram_wdata}, {8'd0, x_wdata});
    end
    if (reset) begin
      n_ack = 0; n_valid = 0; n_rdata = 8'hFF; n_prdata = 8'h00;
      n_ppu = 0; n_flush = 0; p_valid = 0;
    end else begin
      n_ack    = cpu_req && hit && !m_flush;
      n_rdata  = e_rdata;
      if (n_ack && !cpu_we) n_rdata = m_ppu ? 8'hFF : mem[cpu_addr[12:0]];
      n_valid  = m_ppu && ppu_req;
      n_prdata = n_valid ? mem[ppu_addr[12:0]] : e_prdata;
      if (m_flush) p_valid = 0;
      if (POST && m_ppu && cpu_req && cpu_we && hit) begin
        p_valid = 1; p_addr = cpu_addr; p_data = cpu_wdata;
      end
      n_ppu   = !m_flush && (ppu_mode == 2'd3);
      n_flush = m_ppu && (ppu_mode != 2'd3) && p_valid;
    end
    @(posedge clk);
    #1;
    if (x_wren) mem[x_waddr] = x_wdata;
    m_ppu = n_ppu; m_flush = n_flush;
    e_ack = n_ack; e_valid = n_valid; e_rdata = n_rdata; e_prdata = n_prdata;
    chk("cpu_ack", {15'd0, cpu_ack}, {15'd0, e_ack});
    chk("cpu_rdata", {8'd0, cpu_rdata}, {8'd0, e_rdata});
    chk("ppu_valid", {15'd0, ppu_valid}, {15'd0, e_valid});
    chk("ppu_rdata", {8'd0, ppu_rdata}, {8'd0, e_prdata});
    $display("t=%0t rst=%0d mode=%0d creq=%0d we=%0d ca=%h cd=%h preq=%0d pa=%h -> ack=%0d crd=%h pv=%0d prd=%h",
             $time, reset, ppu_mode, cpu_req, cpu_we, cpu_addr, cpu_wdata, ppu_req, ppu_addr,
             cpu_ack, cpu_rdata, ppu_valid, ppu_rdata);
  endtask

  task automatic cpu_set(input logic req, input logic we, input logic [15:0] a, input logic [7:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  initial begin
    int bad;
    for (int a = 0; a < 8192; a++) begin
      vram[a] = 8'(a * 7 + 3);
      mem[a]  = 8'(a * 7 + 3);
    end
    m_ppu = 0; m_flush = 0; p_valid = 0; p_addr = '0; p_data = '0;
    e_ack = 0; e_valid = 0; e_rdata = 8'hFF; e_prdata = 8'h00;
    reset = 1'b1; ppu_mode = 2'd0; ppu_req = 1'b1; ppu_addr = 16'h8000;
    cpu_set(1, 1, 16'h8020, 8'hEE);

    // Reset with a write request held: nothing may be written.
    cycle(); cycle();
    chk("reset_cpu_rdata", {8'd0, cpu_rdata}, 16'h00FF);
    chk("reset_ppu_rdata", {8'd0, ppu_rdata}, 16'h0000);
    reset = 1'b0; ppu_req = 1'b0;

    // Mode 0: write then read back.
    cpu_set(1, 1, 16'h8010, 8'h5A); cycle();
    chk("mode0_write_ack", {15'd0, cpu_ack}, 16'd1);
    cpu_set(1, 0, 16'h8010, 8'h00); cycle();
    chk("mode0_read_data", {8'd0, cpu_rdata}, 16'h005A);
    // Non-VRAM address is ignored.
    cpu_set(1, 1, 16'hA010, 8'h99); cycle();
    chk("nonhit_no_ack", {15'd0, cpu_ack}, 16'd0);

    // Mode 3 for two cycles, then a read gets open bus.
    cpu_set(0, 0, 16'h8010, 8'h00); ppu_mode = 2'd3; cycle(); cycle();
    cpu_set(1, 0, 16'h8010, 8'h00); cycle();
    chk("mode3_read_openbus", {8'd0, cpu_rdata}, 16'h00FF);
    cpu_set(0, 0, 16'h8000, 8'h00); ppu_mode = 2'd0; cycle(); cycle();

    // PPU fetch: preload 0x21 at 0x9800, request in entry cycle is dropped.
    cpu_set(1, 1, 16'h9800, 8'h21); cycle();
    cpu_set(0, 0, 16'h8000, 8'h00);
    ppu_mode = 2'd3; ppu_req = 1'b1; ppu_addr = 16'h9800; cycle();
    chk("ppu_entry_dropped", {15'd0, ppu_valid}, 16'd0);
    cycle();
    chk("ppu_fetch_valid", {15'd0, ppu_valid}, 16'd1);
    chk("ppu_fetch_data", {8'd0, ppu_rdata}, 16'h0021);
    ppu_req = 1'b0;

    // Blocked writes, last one wins; then a read held across the exit.
    cpu_set(1, 1, 16'h8000, 8'h11); cycle();
    cpu_set(1, 1, 16'h8000, 8'h22); cycle();
    cpu_set(1, 0, 16'h8000, 8'h00); ppu_mode = 2'd0;
    for (int i = 0; i < 4; i++) cycle();
    chk("post_read_back", {8'd0, cpu_rdata}, POST ? 16'h0022 : 16'h0003);
    chk("post_vram0", {8'd0, vram[0]}, POST ? 16'h0022 : 16'h0003);

    // Reset while the flush would be in progress: posted write is dropped.
    cpu_set(0, 0, 16'h8000, 8'h00); ppu_mode = 2'd3; cycle();
    cpu_set(1, 1, 16'h8005, 8'h77); cycle();
    cpu_set(0, 0, 16'h8000, 8'h00); ppu_mode = 2'd0; cycle();
    reset = 1'b1; cycle();
    reset = 1'b0; cycle(); cycle();
    chk("reset_flush_nowrite", {8'd0, vram[5]}, 16'h0026);
    chk("reset_flush_ack", {15'd0, cpu_ack}, 16'd0);
    cpu_set(1, 1, 16'h8006, 8'h5C); cycle();
    chk("post_reset_cpu_owner", {15'd0, cpu_ack}, 16'd1);

    // Randomized traffic with mode phases and occasional reset.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0)
        ppu_mode = ($urandom_range(0, 1) == 1) ? 2'd3 : 2'($urandom_range(0, 2));
      cpu_req   = ($urandom_range(0, 2) != 0);
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = ($urandom_range(0, 9) == 0) ? {3'b101, 13'($urandom)} : (16'h8000 | 16'($urandom_range(0, 31)));
      cpu_wdata = 8'($urandom);
      ppu_req   = 1'($urandom_range(0, 1));
      ppu_addr  = 16'h8000 | 16'($urandom_range(0, 31));
      reset     = ($urandom_range(0, 99) == 0);
      cycle();
    end
    reset = 1'b0; cpu_req = 1'b0; ppu_req = 1'b0; ppu_mode = 2'd0;
    for (int i = 0; i < 3; i++) cycle();

    bad = 0;
    for (int a = 0; a < 8192; a++) if (vram[a] !== mem[a]) bad++;
    chk("vram_contents", 16'(bad), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gb_vram_arbiter.md
# gb_vram_arbiter

Arbitrates the single VRAM port between the CPU and the PPU pixel fetcher, based on the current PPU mode. It drives the address, write-data and write-enable pins of the VRAM array (8 KiB, 0x8000–0x9FFF, combinational read, write on clock edge). During PPU mode 3 (drawing) the PPU owns the port: CPU reads return open-bus 0xFF and CPU writes are blocked. In all other modes the CPU owns the port.

## Interface
Parameters:
- none

Ports:
- clk  in  1  M-clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- ppu_mode  in  2  current PPU mode: 0 HBlank, 1 VBlank, 2 OAM scan, 3 draw.
- ppu_req  in  1  PPU fetch request; valid only while the PPU owns the port.
- ppu_addr  in  16  PPU fetch address.
- ppu_rdata  out  8  fetched byte, registered.
- ppu_valid  out  1  one-cycle pulse: ppu_rdata is valid.
- cpu_req  in  1  CPU access request, qualified by a VRAM address hit.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  16  CPU address.
- cpu_wdata  in  8  CPU write data.
- cpu_rdata  out  8  CPU read data, registered.
- cpu_ack  out  1  one-cycle pulse: the CPU access has completed.
- vram_addr  out  16  to the VRAM array.
- vram_wdata  out  8  to the VRAM array.
- vram_wren  out  1  to the VRAM array.
- vram_rdata  in  8  from the VRAM array.

## Operation
- **VRAM hit.** A CPU request counts as a hit when `cpu_addr[15:13] == 3'b100`. Requests that do not hit are ignored: no ack and no write.
- **Owner FSM.** States are S_CPU, S_PPU and S_FLUSH. The reset state is S_CPU.
- **S_CPU.**
  - Port drive: `vram_addr = cpu_addr`; `vram_wren = cpu_req & cpu_we & hit`.
  - Transition: if `ppu_mode == 3`, go to S_PPU next cycle. A CPU access in that same cycle is still serviced.
- **S_PPU.**
  - Port drive: `vram_addr = ppu_addr`; `vram_wren = 0`.
  - CPU reads: acked, with `cpu_rdata = 0xFF`.
  - CPU writes: acked but not performed; see Configuration.
  - Transition: if `ppu_mode != 3`, go to S_FLUSH when a posted write is pending, otherwise to S_CPU.
- **S_FLUSH.**
  - Port drive: `vram_addr`/`vram_wdata` come from the post buffer; `vram_wren = 1`.
  - The buffer is cleared, and the next state is S_CPU.
  - A CPU request in this cycle is stalled: no ack. The CPU holds `cpu_req`, and the request is serviced in S_CPU.
- **PPU requests outside S_PPU** are ignored: `ppu_valid` stays 0.
- **Handshake.** `cpu_req` is level-sensitive. Each serviced cycle produces exactly one `cpu_ack` pulse. A request held high is serviced again on every eligible cycle.
- **Write data.** `vram_wdata = cpu_wdata` in S_CPU and S_PPU.

## Timing
- **Reset values:** `cpu_ack = 0`, `cpu_rdata = 0xFF`, `ppu_valid = 0`, `ppu_rdata = 0x00`, FSM in S_CPU, post buffer empty.
- **`vram_wren` during reset:** forced to 0 combinationally while reset is high.
- **CPU latency:** request in cycle t gives `cpu_ack` and `cpu_rdata` in cycle t+1. For reads, `cpu_rdata` is `vram_rdata` sampled at t.
- **CPU writes:** the write lands on the edge ending cycle t.
- **PPU latency:** `ppu_req` in S_PPU at cycle t gives `ppu_valid` and `ppu_rdata` at t+1.
- **Mode-3 entry:** the first `ppu_req` that can be served is one cycle after `ppu_mode` first reads 3. A request in that first cycle is dropped; the PPU is required to wait one cycle.
- **Mode-3 exit:** the flush costs one cycle. The first CPU access after exit completes at most 2 cycles after `ppu_mode` leaves 3.
- **Reset mid-operation:** any pending posted write is discarded, and any in-flight ack/valid is cleared next cycle.

## Configuration
- **VRAM_WRITE_POST_EN defined:**
  - A single-entry buffer captures CPU writes blocked in S_PPU (address and data).
  - A later blocked write overwrites the entry: last write wins.
  - The entry is committed in S_FLUSH.
- **VRAM_WRITE_POST_EN undefined:**
  - Blocked writes are acked and discarded, matching hardware.
  - S_FLUSH is unreachable, and the buffer logic is absent.

## Structure
- **Package `gb_vram_pkg`:**
  - Typedef `vram_owner_e {S_CPU, S_PPU, S_FLUSH}`.
  - Localparams `PPU_MODE_DRAW = 2'd3`, `VRAM_HIT = 3'b100`, `CPU_OPEN_BUS = 8'hFF`.
- **Sub-module `gb_vram_post_buf`:** the single-entry write buffer (capture, overwrite, clear, pending flag). It is instantiated only under VRAM_WRITE_POST_EN.

## Test plan
- **CPU access, mode 0.** Write 0x5A to 0x8010 at cycle t, then read 0x8010 → ack at t+1 for each access; read returns 0x5A.
- **CPU read, mode 3.** `ppu_mode = 3` for two cycles, then CPU read of 0x8010 → ack next cycle, `cpu_rdata = 0xFF`, `vram_wren` never asserted.
- **PPU fetch.** Mode 3 entered at cycle t, `ppu_req` at 0x9800 at t+1 with VRAM[0x1800] = 0x21 → `ppu_valid` at t+2 with 0x21. A `ppu_req` at cycle t yields no valid.
- **Blocked writes.** Mode 3, writes 0x11 then 0x22 to 0x8000, then mode 0:
  - Macro on: S_FLUSH writes 0x22 to 0x8000.
  - Macro off: VRAM[0] is unchanged.
- **Flush stall.** CPU read held across the mode 3→0 exit with a posted write pending → no ack in the S_FLUSH cycle; ack one cycle later returns the flushed data.
- **Reset mid-flush.** Reset asserted with a posted write pending → no write occurs, FSM is in S_CPU, all outputs are at their reset values.
